// File: rtl/pic_host_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pic_host_sequencer_if
//  Brief    : Bundles the host command port, the vector report and the
//             8259-style PIC pins driven/sampled by pic_host_sequencer.
//             master = sequencer side, slave = host logic + PIC side.
//  Revision : 1.0  initial release
// ============================================================================
interface pic_host_sequencer_if;
  // host command / response port
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rd;
  logic       cmd_a0;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  // interrupt vector report
  logic       vec_valid;
  logic [7:0] vec_data;
  // PIC pins
  logic       int_in;
  logic       cs_n;
  logic       wr_n;
  logic       rd_n;
  logic       inta_n;
  logic       a0;
  logic [7:0] d_out;
  logic       d_oe;
  logic [7:0] d_in;

  modport master (
    input  cmd_valid, cmd_rd, cmd_a0, cmd_wdata, int_in, d_in,
    output cmd_ready, rsp_valid, rsp_rdata, vec_valid, vec_data,
           cs_n, wr_n, rd_n, inta_n, a0, d_out, d_oe
  );

  modport slave (
    output cmd_valid, cmd_rd, cmd_a0, cmd_wdata, int_in, d_in,
    input  cmd_ready, rsp_valid, rsp_rdata, vec_valid, vec_data,
           cs_n, wr_n, rd_n, inta_n, a0, d_out, d_oe
  );
endinterface
`default_nettype wire

// File: rtl/pic_host_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pic_host_sequencer
//  Brief    : CPU-side initiator for an 8259-style PIC. Programs ICW1..ICW4
//             and OCW1 after reset, answers INT with an 8086 INTA pair and
//             captures the vector, and forwards host register reads/writes.
//  Option   : define PIC_HOST_AUTO_EOI_EN to issue a non-specific EOI write
//             (8'h20, a0=0) after every captured vector.
//  Revision : 1.0  initial release
// ============================================================================
module pic_host_sequencer #(
  parameter int         STROBE_CYCLES = 2,
  parameter int         GAP_CYCLES    = 1,
  parameter logic [7:0] ICW1_VAL      = 8'h13,
  parameter logic [7:0] ICW2_VAL      = 8'h20,
  parameter logic [7:0] ICW3_VAL      = 8'h00,
  parameter logic [7:0] ICW4_VAL      = 8'h01,
  parameter logic [7:0] OCW1_VAL      = 8'h00
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_init_start,
  output logic                 o_init_done,
  pic_host_sequencer_if.master pic
);

  localparam int CNT_MAX = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] C_STROBE_LAST = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [7:0]       C_EOI_BYTE    = 8'h20;

  // init write index; ICW3/ICW4 may be skipped depending on ICW1_VAL
  localparam logic [2:0] C_STEP_ICW1 = 3'd0;
  localparam logic [2:0] C_STEP_ICW2 = 3'd1;
  localparam logic [2:0] C_STEP_ICW3 = 3'd2;
  localparam logic [2:0] C_STEP_ICW4 = 3'd3;
  localparam logic [2:0] C_STEP_OCW1 = 3'd4;

  // BOOT only lasts for the first clock after reset release
  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_INIT  = 3'd1,
    ST_IDLE  = 3'd2,
    ST_CMD   = 3'd3,
    ST_INTA1 = 3'd4,
    ST_INTA2 = 3'd5,
    ST_EOI   = 3'd6
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_phase, w_phase_nxt;      // 0 = STROBE, 1 = RECOVER
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_step, w_step_nxt;

  logic       r_int_meta, r_int_sync;
  logic       r_init_done;
  logic       r_cmd_rd, r_cmd_a0;
  logic [7:0] r_cmd_wdata;
  logic       r_rsp_valid, r_vec_valid;
  logic [7:0] r_rsp_rdata, r_vec_data;

  logic       w_access, w_strobe, w_strobe_last;
  logic       w_cmd_ready, w_cmd_accept, w_init_clear, w_init_finish;
  logic       w_cs_n, w_wr_n, w_rd_n, w_inta_n, w_a0, w_d_oe;
  logic [7:0] w_d_out;

  function automatic logic [7:0] f_init_byte(input logic [2:0] step);
    logic [7:0] v;
    case (step)
      C_STEP_ICW1: v = ICW1_VAL;
      C_STEP_ICW2: v = ICW2_VAL;
      C_STEP_ICW3: v = ICW3_VAL;
      C_STEP_ICW4: v = ICW4_VAL;
      default:     v = OCW1_VAL;
    endcase
    return v;
  endfunction

  // ICW3 only in cascade mode (SNGL=0), ICW4 only when IC4=1
  function automatic logic [2:0] f_next_step(input logic [2:0] step);
    logic [2:0] v;
    case (step)
      C_STEP_ICW1: v = C_STEP_ICW2;
      C_STEP_ICW2: v = !ICW1_VAL[1] ? C_STEP_ICW3 : (ICW1_VAL[0] ? C_STEP_ICW4 : C_STEP_OCW1);
      C_STEP_ICW3: v = ICW1_VAL[0] ? C_STEP_ICW4 : C_STEP_OCW1;
      default:     v = C_STEP_OCW1;
    endcase
    return v;
  endfunction

  assign w_access = (r_state == ST_INIT) || (r_state == ST_CMD) || (r_state == ST_INTA1) ||
                    (r_state == ST_INTA2) || (r_state == ST_EOI);
  assign w_strobe      = w_access && !r_phase;
  assign w_strobe_last = w_strobe && (r_cnt == C_STROBE_LAST);
  assign w_cmd_ready   = (r_state == ST_IDLE) && r_init_done && !r_int_sync;

  // Next-state, transfer-engine sequencing and PIC pin decode
  always_comb begin
    w_state_nxt   = r_state;
    w_phase_nxt   = r_phase;
    w_cnt_nxt     = r_cnt;
    w_step_nxt    = r_step;
    w_cmd_accept  = 1'b0;
    w_init_clear  = 1'b0;
    w_init_finish = 1'b0;
    w_cs_n        = 1'b1;
    w_wr_n        = 1'b1;
    w_rd_n        = 1'b1;
    w_inta_n      = 1'b1;
    w_a0          = 1'b0;
    w_d_out       = 8'h00;
    w_d_oe        = 1'b0;

    if (w_access) begin
      if (!r_phase) begin
        if (r_cnt == C_STROBE_LAST) begin
          w_phase_nxt = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end else if (r_cnt != C_GAP_LAST) begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end else begin
        // end of RECOVER: the access is complete
        w_phase_nxt = 1'b0;
        w_cnt_nxt   = '0;
        case (r_state)
          ST_INIT: begin
            if (r_step == C_STEP_OCW1) begin
              w_state_nxt   = ST_IDLE;
              w_init_finish = 1'b1;
            end else begin
              w_step_nxt = f_next_step(r_step);
            end
          end
          ST_INTA1: w_state_nxt = ST_INTA2;
          ST_INTA2: begin
`ifdef PIC_HOST_AUTO_EOI_EN
            w_state_nxt = ST_EOI;
`else
            w_state_nxt = ST_IDLE;
`endif
          end
          default:  w_state_nxt = ST_IDLE;
        endcase
      end
    end else if (r_state == ST_BOOT) begin
      w_state_nxt = ST_INIT;
      w_step_nxt  = C_STEP_ICW1;
    end else begin
      // IDLE: a pending INT beats a command; an accepted command beats init_start
      if (r_int_sync) begin
        w_state_nxt = ST_INTA1;
      end else if (pic.cmd_valid && w_cmd_ready) begin
        w_state_nxt  = ST_CMD;
        w_cmd_accept = 1'b1;
      end else if (i_init_start) begin
        w_state_nxt  = ST_INIT;
        w_step_nxt   = C_STEP_ICW1;
        w_init_clear = 1'b1;
      end
    end

    case (r_state)
      ST_INIT: begin
        w_a0    = (r_step != C_STEP_ICW1);
        w_d_out = f_init_byte(r_step);
        if (w_strobe) begin
          w_cs_n = 1'b0;
          w_wr_n = 1'b0;
          w_d_oe = 1'b1;
        end
      end
      ST_CMD: begin
        w_a0 = r_cmd_a0;
        if (r_cmd_rd) begin
          if (w_strobe) begin
            w_cs_n = 1'b0;
            w_rd_n = 1'b0;
          end
        end else begin
          w_d_out = r_cmd_wdata;
          if (w_strobe) begin
            w_cs_n = 1'b0;
            w_wr_n = 1'b0;
            w_d_oe = 1'b1;
          end
        end
      end
      ST_INTA1, ST_INTA2: begin
        if (w_strobe) w_inta_n = 1'b0;
      end
      ST_EOI: begin
        w_d_out = C_EOI_BYTE;
        if (w_strobe) begin
          w_cs_n = 1'b0;
          w_wr_n = 1'b0;
          w_d_oe = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Two-flop synchroniser for the asynchronous INT pin
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_int_meta <= 1'b0;
      r_int_sync <= 1'b0;
    end else begin
      r_int_meta <= pic.int_in;
      r_int_sync <= r_int_meta;
    end
  end

  // FSM and transfer-engine state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_BOOT;
      r_phase <= 1'b0;
      r_cnt   <= '0;
      r_step  <= C_STEP_ICW1;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_cnt   <= w_cnt_nxt;
      r_step  <= w_step_nxt;
    end
  end

  // Hold the accepted command for the whole transfer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd_rd    <= 1'b0;
      r_cmd_a0    <= 1'b0;
      r_cmd_wdata <= 8'h00;
    end else if (w_cmd_accept) begin
      r_cmd_rd    <= pic.cmd_rd;
      r_cmd_a0    <= pic.cmd_a0;
      r_cmd_wdata <= pic.cmd_wdata;
    end
  end

  // init_done: cleared when a re-init starts, set when OCW1 recovery ends
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_init_done <= 1'b0;
    end else if (w_init_clear) begin
      r_init_done <= 1'b0;
    end else if (w_init_finish) begin
      r_init_done <= 1'b1;
    end
  end

  // Capture read data / vector on the last strobe clock; valid pulses next clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 8'h00;
      r_vec_valid <= 1'b0;
      r_vec_data  <= 8'h00;
    end else begin
      r_rsp_valid <= w_strobe_last && (r_state == ST_CMD) && r_cmd_rd;
      r_vec_valid <= w_strobe_last && (r_state == ST_INTA2);
      if (w_strobe_last && (r_state == ST_CMD) && r_cmd_rd) r_rsp_rdata <= pic.d_in;
      if (w_strobe_last && (r_state == ST_INTA2))           r_vec_data  <= pic.d_in;
    end
  end

  assign o_init_done   = r_init_done;
  assign pic.cmd_ready = w_cmd_ready;
  assign pic.rsp_valid = r_rsp_valid;
  assign pic.rsp_rdata = r_rsp_rdata;
  assign pic.vec_valid = r_vec_valid;
  assign pic.vec_data  = r_vec_data;
  assign pic.cs_n      = w_cs_n;
  assign pic.wr_n      = w_wr_n;
  assign pic.rd_n      = w_rd_n;
  assign pic.inta_n    = w_inta_n;
  assign pic.a0        = w_a0;
  assign pic.d_out     = w_d_out;
  assign pic.d_oe      = w_d_oe;

endmodule
`default_nettype wire

// File: tb/tb_pic_host_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_pic_host_sequencer
//  Brief    : Directed self-checking bench for pic_host_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pic_host_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic init_start;
  logic init_done;
  int   n_vec = 0;
  int   n_err = 0;

  logic [7:0] exp_d  [0:3];
  logic       exp_a0 [0:3];

  pic_host_sequencer_if pic();

  pic_host_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .i_init_start (init_start),
    .o_init_done  (init_done),
    .pic          (pic)
  );

  always #5 clk = ~clk;

  // advance one clock and settle just after the active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reset just released: expect 13@0, 20@1, 01@1, 00@1, each 2 low + 1 gap, done at clock 13
  task automatic run_init_seq(input string tag);
    int  idx, ph;
    logic ew;
    for (int k = 1; k <= 13; k++) begin
      tick();
      idx = (k - 1) / 3;
      ph  = (k - 1) % 3;
      ew  = (k <= 12 && ph != 2) ? 1'b0 : 1'b1;
      n_vec++;
      if ({pic.wr_n, pic.cs_n, pic.d_oe, pic.rd_n, pic.inta_n} !== {ew, ew, ~ew, 1'b1, 1'b1}) begin
        n_err++;
        $display("FAIL %s_strobes clk%0d: got wr/cs/oe/rd/inta=%b want %b", tag, k,
                 {pic.wr_n, pic.cs_n, pic.d_oe, pic.rd_n, pic.inta_n}, {ew, ew, ~ew, 1'b1, 1'b1});
      end
      if (!ew) begin
        n_vec++;
        if ({pic.a0, pic.d_out} !== {exp_a0[idx], exp_d[idx]}) begin
          n_err++;
          $display("FAIL %s_data clk%0d: got a0=%b d=%h want a0=%b d=%h", tag, k,
                   pic.a0, pic.d_out, exp_a0[idx], exp_d[idx]);
        end
      end
      n_vec++;
      if (init_done !== (k == 13)) begin
        n_err++;
        $display("FAIL %s_init_done clk%0d: got %b want %b", tag, k, init_done, (k == 13));
      end
    end
    n_vec++;
    if (pic.cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s_cmd_ready: got %b want 1", tag, pic.cmd_ready);
    end
  endtask

  task automatic test_reset();
    reset           = 1'b1;
    init_start      = 1'b0;
    pic.cmd_valid   = 1'b0;
    pic.cmd_rd      = 1'b0;
    pic.cmd_a0      = 1'b0;
    pic.cmd_wdata   = 8'h00;
    pic.int_in      = 1'b0;
    pic.d_in        = 8'h00;
    tick();
    tick();
    n_vec++;
    if ({pic.cs_n, pic.wr_n, pic.rd_n, pic.inta_n, pic.a0, pic.d_out, pic.d_oe} !== {4'b1111, 1'b0, 8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL reset_pins: got cs/wr/rd/inta=%b a0=%b d=%h oe=%b want 1111 0 00 0",
               {pic.cs_n, pic.wr_n, pic.rd_n, pic.inta_n}, pic.a0, pic.d_out, pic.d_oe);
    end
    n_vec++;
    if ({init_done, pic.cmd_ready, pic.rsp_valid, pic.vec_valid, pic.rsp_rdata, pic.vec_data} !== 20'h0) begin
      n_err++;
      $display("FAIL reset_status: got done/rdy/rsp/vec=%b rdata=%h vdata=%h want 0000 00 00",
               {init_done, pic.cmd_ready, pic.rsp_valid, pic.vec_valid}, pic.rsp_rdata, pic.vec_data);
    end
    reset = 1'b0;
    run_init_seq("init");
  endtask

  task automatic test_inta();
    int lat;
    logic [9:0] ei, ev, ew, ecr;
    ei  = 10'b11111_00100;
    ev  = 10'b00001_00000;
`ifdef PIC_HOST_AUTO_EOI_EN
    ew  = 10'b1100111111;
    ecr = 10'b1000000000;
`else
    ew  = 10'b1111111111;
    ecr = 10'b1111000000;
`endif
    pic.d_in   = 8'h24;
    pic.int_in = 1'b1;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (!pic.inta_n) begin
        lat = c;
        break;
      end
    end
    n_vec++;
    if (lat != 3) begin
      n_err++;
      $display("FAIL inta_latency: got %0d clocks want 3", lat);
    end
    pic.int_in = 1'b0;
    if (lat < 0) return;
    for (int j = 0; j < 10; j++) begin
      if (j > 0) tick();
      n_vec++;
      if ({pic.inta_n, pic.cs_n, pic.wr_n, pic.rd_n, pic.d_oe, pic.vec_valid, pic.cmd_ready} !==
          {ei[j], ew[j], ew[j], 1'b1, ~ew[j], ev[j], ecr[j]}) begin
        n_err++;
        $display("FAIL inta_seq j%0d: got inta/cs/wr/rd/oe/vv/rdy=%b want %b", j,
                 {pic.inta_n, pic.cs_n, pic.wr_n, pic.rd_n, pic.d_oe, pic.vec_valid, pic.cmd_ready},
                 {ei[j], ew[j], ew[j], 1'b1, ~ew[j], ev[j], ecr[j]});
      end
      if (j >= 5) begin
        n_vec++;
        if (pic.vec_data !== 8'h24) begin
          n_err++;
          $display("FAIL inta_vec_data j%0d: got %h want 24", j, pic.vec_data);
        end
        pic.d_in = 8'h00;
      end
      if (!ew[j]) begin
        n_vec++;
        if ({pic.a0, pic.d_out} !== {1'b0, 8'h20}) begin
          n_err++;
          $display("FAIL inta_eoi_data j%0d: got a0=%b d=%h want a0=0 d=20", j, pic.a0, pic.d_out);
        end
      end
    end
  endtask

  task automatic test_cmd_write();
    logic [5:0] exp;
    for (int c = 0; c < 50 && !pic.cmd_ready; c++) tick();
    n_vec++;
    if (pic.cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL wr_wait_ready: got %b want 1", pic.cmd_ready);
    end
    pic.cmd_valid = 1'b1;
    pic.cmd_rd    = 1'b0;
    pic.cmd_a0    = 1'b0;
    pic.cmd_wdata = 8'h0B;
    tick();
    pic.cmd_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) tick();
      exp = (j < 2) ? 6'b010110 : ((j == 2) ? 6'b111010 : 6'b111011);
      n_vec++;
      if ({pic.wr_n, pic.rd_n, pic.cs_n, pic.d_oe, pic.inta_n, pic.cmd_ready} !== exp) begin
        n_err++;
        $display("FAIL wr_seq j%0d: got wr/rd/cs/oe/inta/rdy=%b want %b", j,
                 {pic.wr_n, pic.rd_n, pic.cs_n, pic.d_oe, pic.inta_n, pic.cmd_ready}, exp);
      end
      if (j < 2) begin
        n_vec++;
        if ({pic.a0, pic.d_out} !== {1'b0, 8'h0B}) begin
          n_err++;
          $display("FAIL wr_data j%0d: got a0=%b d=%h want a0=0 d=0b", j, pic.a0, pic.d_out);
        end
      end
    end
  endtask

  task automatic test_cmd_read();
    logic [5:0] exp;
    for (int c = 0; c < 50 && !pic.cmd_ready; c++) tick();
    n_vec++;
    if (pic.cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rd_wait_ready: got %b want 1", pic.cmd_ready);
    end
    pic.cmd_valid = 1'b1;
    pic.cmd_rd    = 1'b1;
    pic.cmd_a0    = 1'b0;
    pic.d_in      = 8'h80;
    tick();
    pic.cmd_valid = 1'b0;
    pic.cmd_rd    = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) tick();
      // wr_n, rd_n, cs_n, d_oe, rsp_valid, cmd_ready
      exp = (j < 2) ? 6'b100000 : ((j == 2) ? 6'b111010 : 6'b111001);
      n_vec++;
      if ({pic.wr_n, pic.rd_n, pic.cs_n, pic.d_oe, pic.rsp_valid, pic.cmd_ready} !== exp) begin
        n_err++;
        $display("FAIL rd_seq j%0d: got wr/rd/cs/oe/rv/rdy=%b want %b", j,
                 {pic.wr_n, pic.rd_n, pic.cs_n, pic.d_oe, pic.rsp_valid, pic.cmd_ready}, exp);
      end
      if (j >= 2) begin
        n_vec++;
        if (pic.rsp_rdata !== 8'h80) begin
          n_err++;
          $display("FAIL rd_rdata j%0d: got %h want 80", j, pic.rsp_rdata);
        end
        pic.d_in = 8'h00;
      end
    end
  endtask

  // synchronised INT and cmd_valid reach the FSM on the same clock
  task automatic test_back_to_back();
    int   first_inta, vec_c, acc_c, n_inta, n_wr;
    int   wr_c [0:1];
    logic [8:0] wr_v [0:1];
    logic prev_inta, prev_wr, drop_pend;
    int   exp_acc, exp_wr0, exp_wr1;
    logic [8:0] exp_wv0;
`ifdef PIC_HOST_AUTO_EOI_EN
    exp_acc = 10; exp_wr0 = 7; exp_wr1 = 11; exp_wv0 = {1'b0, 8'h20};
`else
    exp_acc = 7;  exp_wr0 = 8; exp_wr1 = -1; exp_wv0 = {1'b1, 8'h5A};
`endif
    for (int c = 0; c < 50 && !pic.cmd_ready; c++) tick();
    pic.d_in   = 8'h27;
    pic.int_in = 1'b1;
    tick();
    tick();
    pic.cmd_valid = 1'b1;
    pic.cmd_rd    = 1'b0;
    pic.cmd_a0    = 1'b1;
    pic.cmd_wdata = 8'h5A;
    n_vec++;
    if (pic.cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_ready_blocked: got %b want 0", pic.cmd_ready);
    end
    first_inta = -1; vec_c = -1; acc_c = -1; n_inta = 0; n_wr = 0;
    wr_c[0] = -1; wr_c[1] = -1; wr_v[0] = '0; wr_v[1] = '0;
    prev_inta = 1'b1; prev_wr = 1'b1; drop_pend = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (drop_pend) begin
        pic.cmd_valid = 1'b0;
        drop_pend     = 1'b0;
      end
      if (!pic.inta_n && prev_inta) begin
        n_inta++;
        if (first_inta < 0) begin
          first_inta = c;
          pic.int_in = 1'b0;
        end
      end
      if (!pic.wr_n && prev_wr && n_wr < 2) begin
        wr_c[n_wr] = c;
        wr_v[n_wr] = {pic.a0, pic.d_out};
        n_wr++;
      end
      if (pic.vec_valid) vec_c = c;
      if (pic.cmd_valid && pic.cmd_ready) begin
        acc_c     = c;
        drop_pend = 1'b1;
      end
      prev_inta = pic.inta_n;
      prev_wr   = pic.wr_n;
    end
    n_vec++;
    if (first_inta != 1 || n_inta != 2 || vec_c != 6) begin
      n_err++;
      $display("FAIL b2b_inta: got first=%0d pulses=%0d vec@%0d want first=1 pulses=2 vec@6",
               first_inta, n_inta, vec_c);
    end
    n_vec++;
    if (acc_c != exp_acc) begin
      n_err++;
      $display("FAIL b2b_accept: got clock %0d want %0d", acc_c, exp_acc);
    end
    n_vec++;
    if (wr_c[0] != exp_wr0 || wr_v[0] !== exp_wv0) begin
      n_err++;
      $display("FAIL b2b_wr0: got clk%0d a0/d=%h want clk%0d %h", wr_c[0], wr_v[0], exp_wr0, exp_wv0);
    end
    n_vec++;
    if (wr_c[1] != exp_wr1 || (exp_wr1 > 0 && wr_v[1] !== {1'b1, 8'h5A})) begin
      n_err++;
      $display("FAIL b2b_wr1: got clk%0d a0/d=%h want clk%0d", wr_c[1], wr_v[1], exp_wr1);
    end
  endtask

  task automatic test_reset_mid_inta();
    int lat;
    for (int c = 0; c < 50 && !pic.cmd_ready; c++) tick();
    pic.int_in = 1'b1;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (!pic.inta_n) begin
        lat = c;
        break;
      end
    end
    n_vec++;
    if (lat < 0) begin
      n_err++;
      $display("FAIL rst_inta_wait: got no inta_n pulse want one");
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if ({pic.inta_n, pic.cs_n, pic.wr_n, init_done} !== 4'b1110) begin
      n_err++;
      $display("FAIL rst_async: got inta/cs/wr/done=%b want 1110",
               {pic.inta_n, pic.cs_n, pic.wr_n, init_done});
    end
    pic.int_in = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    run_init_seq("reinit");
  endtask

  initial begin
    exp_d[0] = 8'h13; exp_a0[0] = 1'b0;
    exp_d[1] = 8'h20; exp_a0[1] = 1'b1;
    exp_d[2] = 8'h01; exp_a0[2] = 1'b1;
    exp_d[3] = 8'h00; exp_a0[3] = 1'b1;
    test_reset();
    test_inta();
    test_cmd_write();
    test_cmd_read();
    test_back_to_back();
    test_reset_mid_inta();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
